// File: rtl/booths_divider.sv
// Sequential signed divider: radix-2 restoring division on magnitudes, one quotient
// bit per clock, then a sign-correction step. Shares the start/valid handshake with the Booth multiplier.
module booths_divider #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] X,
  input  logic signed [WIDTH-1:0] Y,
  output logic signed [WIDTH-1:0] Q,
  output logic signed [WIDTH-1:0] R,
  output logic                    dz,
  output logic                    busy,
  output logic                    valid
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic             sx, sy, zdiv;
  logic [WIDTH-1:0] ax, ay, qreg, prem;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   shifted, trial;

  // Magnitude of a two's-complement value; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return v[WIDTH-1] ? (~u + WIDTH'(1)) : u;
  endfunction

  // Conditional two's-complement negation, wrapping on overflow.
  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Working remainder is one bit wider than the stored one so the trial sign is visible.
  always_comb begin
    shifted = {prem, qreg[WIDTH-1]};
    trial   = shifted - {1'b0, ay};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sx    <= 1'b0;
      sy    <= 1'b0;
      zdiv  <= 1'b0;
      ax    <= '0;
      ay    <= '0;
      qreg  <= '0;
      prem  <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
      dz    <= 1'b0;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            sx    <= X[WIDTH-1];
            sy    <= Y[WIDTH-1];
            ax    <= mag(X);
            ay    <= mag(Y);
            zdiv  <= (Y == '0);
            prem  <= '0;
            qreg  <= mag(X);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          if (cnt == CNT_W'(WIDTH)) begin
            if (zdiv) begin
              Q  <= '1;
              R  <= cneg(ax, sx);
              dz <= 1'b1;
            end else begin
              Q  <= cneg(qreg, sx ^ sy);
              R  <= cneg(prem, sx);
              dz <= 1'b0;
            end
            valid <= 1'b1;
            state <= FIX;
          end else begin
            if (!trial[WIDTH]) begin
              prem <= trial[WIDTH-1:0];
              qreg <= {qreg[WIDTH-2:0], 1'b1};
            end else begin
              prem <= shifted[WIDTH-1:0];
              qreg <= {qreg[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booths_divider.sv
// Bench for booths_divider at WIDTH=4 and WIDTH=8 against a truncating-division
// reference model, with literal expectations on the directed vectors.
module tb_booths_divider;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  logic              start4 = 1'b0;
  logic signed [3:0] X4 = '0, Y4 = '0;
  logic signed [3:0] Q4, R4;
  logic              dz4, busy4, valid4;

  logic              start8 = 1'b0;
  logic signed [7:0] X8 = '0, Y8 = '0;
  logic signed [7:0] Q8, R8;
  logic              dz8, busy8, valid8;

  booths_divider #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .X(X4), .Y(Y4),
    .Q(Q4), .R(R4), .dz(dz4), .busy(busy4), .valid(valid4)
  );

  booths_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .X(X8), .Y(Y8),
    .Q(Q8), .R(R8), .dz(dz8), .busy(busy8), .valid(valid8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] q, r;
    bit         dz;
    bit         lit;
    logic [7:0] lq, lr;
    bit         ldz;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: plain integer division truncates toward zero, remainder follows dividend.
  function automatic void model(input int x, input int y, input int w,
                                output logic [7:0] q, output logic [7:0] r, output bit d);
    int mask, qq, rr;
    mask = (1 << w) - 1;
    if (y == 0) begin
      qq = -1; rr = x; d = 1'b1;
    end else begin
      qq = x / y; rr = x % y; d = 1'b0;
    end
    q = 8'(qq & mask);
    r = 8'(rr & mask);
  endfunction

  logic [8:0]  last4 = '0;
  logic [16:0] last8 = '0;

  always @(negedge clk) begin : cmp
    exp_t e;
    if (rst) begin
      chk("rst_out4", int'({Q4, R4, dz4, valid4, busy4}), 0);
      chk("rst_out8", int'({Q8, R8, dz8, valid8, busy8}), 0);
      last4 = '0;
      last8 = '0;
    end else begin
      if (valid4) begin
        if (q4.size() == 0) chk("spurious_valid4", 1, 0);
        else begin
          e = q4.pop_front();
          chk("lat4", cyc, e.due);
          chk("Q4", int'({4'b0, Q4}), int'(e.q));
          chk("R4", int'({4'b0, R4}), int'(e.r));
          chk("dz4", int'(dz4), int'(e.dz));
          if (e.lit) begin
            chk("litQ4", int'({4'b0, Q4}), int'(e.lq));
            chk("litR4", int'({4'b0, R4}), int'(e.lr));
            chk("litdz4", int'(dz4), int'(e.ldz));
          end
        end
        last4 = {Q4, R4, dz4};
      end else begin
        chk("hold4", int'({Q4, R4, dz4}), int'(last4));
        if (q4.size() != 0 && cyc > q4[0].due) begin
          chk("timeout4", cyc, q4[0].due);
          void'(q4.pop_front());
        end
      end
      if (valid8) begin
        if (q8.size() == 0) chk("spurious_valid8", 1, 0);
        else begin
          e = q8.pop_front();
          chk("lat8", cyc, e.due);
          chk("Q8", int'(Q8 & 8'hFF), int'(e.q));
          chk("R8", int'(R8 & 8'hFF), int'(e.r));
          chk("dz8", int'(dz8), int'(e.dz));
        end
        last8 = {Q8, R8, dz8};
      end else begin
        chk("hold8", int'({Q8, R8, dz8}), int'(last8));
        if (q8.size() != 0 && cyc > q8[0].due) begin
          chk("timeout8", cyc, q8[0].due);
          void'(q8.pop_front());
        end
      end
    end
  end

  task automatic wait_idle4();
    int n;
    @(negedge clk);
    n = 0;
    while (busy4 !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("idle4_wait", int'(busy4), 0);
  endtask

  task automatic op4(input logic signed [3:0] x, input logic signed [3:0] y, input bit lit,
                     input logic [3:0] lq, input logic [3:0] lr, input bit ldz, input bit tog);
    exp_t e;
    logic [7:0] mq, mr;
    bit md;
    int n;
    wait_idle4();
    model(int'(x), int'(y), 4, mq, mr, md);
    e.due = cyc + 6; e.q = mq; e.r = mr; e.dz = md;
    e.lit = lit; e.lq = {4'b0, lq}; e.lr = {4'b0, lr}; e.ldz = ldz;
    X4 = x; Y4 = y; start4 = 1'b1;
    q4.push_back(e);
    @(negedge clk);
    if (tog) begin
      repeat (4) begin
        X4 = 4'($urandom); Y4 = 4'($urandom); start4 = 1'($urandom);
        @(negedge clk);
      end
    end
    start4 = 1'b0;
    n = 0;
    while (q4.size() != 0 && n < 30) begin @(negedge clk); n++; end
  endtask

  task automatic hold4(input logic signed [3:0] x, input logic signed [3:0] y);
    exp_t e;
    logic [7:0] mq, mr;
    bit md;
    int n;
    wait_idle4();
    model(int'(x), int'(y), 4, mq, mr, md);
    e.q = mq; e.r = mr; e.dz = md; e.lit = 1'b0; e.lq = '0; e.lr = '0; e.ldz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e.due = cyc + 6 + 7 * i;
      q4.push_back(e);
    end
    X4 = x; Y4 = y; start4 = 1'b1;
    repeat (20) @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (q4.size() != 0 && n < 30) begin @(negedge clk); n++; end
  endtask

  task automatic op8(input logic signed [7:0] x, input logic signed [7:0] y);
    exp_t e;
    logic [7:0] mq, mr;
    bit md;
    int n;
    @(negedge clk);
    n = 0;
    while (busy8 !== 1'b0 && n < 30) begin @(negedge clk); n++; end
    if (n >= 30) chk("idle8_wait", int'(busy8), 0);
    model(int'(x), int'(y), 8, mq, mr, md);
    e.due = cyc + 10; e.q = mq; e.r = mr; e.dz = md;
    e.lit = 1'b0; e.lq = '0; e.lr = '0; e.ldz = 1'b0;
    X8 = x; Y8 = y; start8 = 1'b1;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (q8.size() != 0 && n < 40) begin @(negedge clk); n++; end
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    op4(4'sd7,  4'sd2,  1, 4'h3, 4'h1, 0, 0);
    op4(-4'sd7, 4'sd2,  1, 4'hD, 4'hF, 0, 0);
    op4(4'sd7,  -4'sd2, 1, 4'hD, 4'h1, 0, 0);
    op4(-4'sd7, -4'sd2, 1, 4'h3, 4'hF, 0, 0);
    op4(-4'sd8, -4'sd1, 1, 4'h8, 4'h0, 0, 0);
    op4(-4'sd8, 4'sd3,  1, 4'hE, 4'hE, 0, 0);
    op4(4'sd3,  4'sd7,  1, 4'h0, 4'h3, 0, 0);
    op4(4'sd0,  -4'sd5, 1, 4'h0, 4'h0, 0, 0);
    op4(4'sd5,  4'sd0,  1, 4'hF, 4'h5, 1, 0);
    op4(4'sd6,  4'sd3,  1, 4'h2, 4'h0, 0, 0);
    op4(-4'sd7, 4'sd3,  1, 4'hE, 4'hF, 0, 1);

    // Abandon an operation mid-iteration with an asynchronous reset.
    wait_idle4();
    X4 = 4'sd5; Y4 = 4'sd2; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst4", int'({Q4, R4, dz4, valid4, busy4}), 0);
    q4.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    op4(4'sd7, 4'sd2, 1, 4'h3, 4'h1, 0, 0);

    hold4(4'sd6, 4'sd3);

    for (int xi = -8; xi < 8; xi++)
      for (int yi = -8; yi < 8; yi++)
        op4(4'(xi), 4'(yi), 0, 4'h0, 4'h0, 0, 0);

    op8(-8'sd128, -8'sd1);
    op8(-8'sd128, 8'sd0);
    op8(8'sd127, -8'sd128);
    op8(-8'sd1, 8'sd127);
    op8(8'sd100, 8'sd7);
    for (int i = 0; i < 150; i++) op8(8'($urandom), 8'($urandom));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
